// File: rtl/seg_load_if.sv
// seg_load_if: valid/ready load channel carrying NDIG hex nibbles into seg_scan_ctrl.
interface seg_load_if #(
   parameter int unsigned NDIG = 4
) ();
   logic              load_valid;
   logic [4*NDIG-1:0] load_data;
   logic              load_ready;

   modport master (output load_valid, output load_data, input load_ready);
   modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed NDIG-digit active-low 7-segment scanner with blank gaps and
// frame-synchronous value commit. Define LZ_BLANK_EN for leading-zero blanking.
module seg_scan_ctrl #(
   parameter int unsigned NDIG     = 4,
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned CW       = 16
) (
   input  logic            clki,
   input  logic            rst,
   input  logic            en,
   seg_load_if.slave       load,
   input  logic [NDIG-1:0] dp_mask,
   output logic [7:0]      disp,
   output logic [NDIG-1:0] an,
   output logic            frame_done
);
   localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [1:0] {StIdle, StDrive, StBlank} state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [4*NDIG-1:0] shadow_q, shadow_d;
   logic [4*NDIG-1:0] pend_q, pend_d;
   logic              pend_vld_q, pend_vld_d;
   logic [7:0]        disp_q, disp_d;
   logic [NDIG-1:0]   an_q, an_d;
   logic              tick, wrap;
   logic [3:0]        nib;
   int unsigned       sel;

   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'h0: seg7 = 7'h40;
         4'h1: seg7 = 7'h79;
         4'h2: seg7 = 7'h24;
         4'h3: seg7 = 7'h30;
         4'h4: seg7 = 7'h19;
         4'h5: seg7 = 7'h12;
         4'h6: seg7 = 7'h02;
         4'h7: seg7 = 7'h78;
         4'h8: seg7 = 7'h00;
         4'h9: seg7 = 7'h10;
         4'hA: seg7 = 7'h08;
         4'hB: seg7 = 7'h03;
         4'hC: seg7 = 7'h46;
         4'hD: seg7 = 7'h21;
         4'hE: seg7 = 7'h06;
         default: seg7 = 7'h0E;
      endcase
   endfunction

   assign tick           = en && (state_q == StDrive) && (cnt_q == CW'(SCAN_DIV - 1));
   assign wrap           = tick && (idx_q == IW'(NDIG - 1));
   assign frame_done     = wrap;
   assign load.load_ready = ~pend_vld_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      shadow_d   = shadow_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      unique case (state_q)
         StIdle: if (en) state_d = StDrive;
         StDrive: begin
            if (tick) begin
               cnt_d   = '0;
               state_d = StBlank;
               idx_d   = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
            end else if (en) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StBlank: state_d = StDrive;
         default: state_d = StIdle;
      endcase
      // Commit uses only what was pending before this cycle; a same-cycle load waits a frame.
      if (wrap && pend_vld_q) begin
         shadow_d   = pend_q;
         pend_vld_d = 1'b0;
      end
      if (load.load_valid && !pend_vld_q) begin
         pend_d     = load.load_data;
         pend_vld_d = 1'b1;
      end
   end

   // Outputs are registered from next-state so the digit appears with its DRIVE state.
   always_comb begin
      disp_d = 8'hFF;
      an_d   = '1;
      sel    = 32'(idx_d);
      nib    = 4'(shadow_d >> (4 * sel));
      if (state_d == StDrive) begin
         an_d[idx_d] = 1'b0;
         disp_d      = {~dp_mask[idx_d], seg7(nib)};
`ifdef LZ_BLANK_EN
         if ((idx_d != '0) && ((shadow_d >> (4 * sel)) == '0)) disp_d[6:0] = 7'h7F;
`endif
      end
   end

   always_ff @(posedge clki) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         idx_q      <= '0;
         shadow_q   <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         disp_q     <= 8'hFF;
         an_q       <= '1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shadow_q   <= shadow_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         disp_q     <= disp_d;
         an_q       <= an_d;
      end
   end

   assign disp = disp_q;
   assign an   = an_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed and random checks of seg_scan_ctrl (NDIG=4, SCAN_DIV=4) against a
// slot-countdown reference model.
module tb_seg_scan_ctrl;
   localparam int unsigned NDIG     = 4;
   localparam int unsigned SCAN_DIV = 4;
   localparam int unsigned CW       = 16;

   logic            clki = 1'b0;
   logic            rst  = 1'b1;
   logic            en   = 1'b0;
   logic [NDIG-1:0] dp_mask = '0;
   logic [7:0]      disp;
   logic [NDIG-1:0] an;
   logic            frame_done;

   seg_load_if #(.NDIG(NDIG)) load_bus ();

   seg_scan_ctrl #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .CW(CW)) dut (
      .clki       (clki),
      .rst        (rst),
      .en         (en),
      .load       (load_bus),
      .dp_mask    (dp_mask),
      .disp       (disp),
      .an         (an),
      .frame_done (frame_done)
   );

   always #5 clki = ~clki;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   logic [7:0] segtab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // Reference model: running flag, blank flag, drive cycles left in slot, current digit.
   bit                chk_on = 1'b0;
   bit                m_run, m_blank;
   int                m_left, m_dig;
   logic [4*NDIG-1:0] m_shadow;
   logic [NDIG-1:0]   m_dp;
   logic [4*NDIG-1:0] pend [$];

   always @(posedge clki) begin
      bit fire;
      if (rst) begin
         chk_on   = 1'b1;
         m_run    = 1'b0;
         m_blank  = 1'b0;
         m_left   = SCAN_DIV;
         m_dig    = 0;
         m_shadow = '0;
         pend.delete();
      end else begin
         fire = load_bus.load_valid && (pend.size() == 0);
         if (!m_run) begin
            if (en) begin
               m_run  = 1'b1;
               m_left = SCAN_DIV;
            end
         end else if (m_blank) begin
            m_blank = 1'b0;
            m_left  = SCAN_DIV;
         end else if (en) begin
            if (m_left == 1) begin
               if (m_dig == NDIG - 1 && pend.size() != 0) m_shadow = pend.pop_front();
               m_dig   = (m_dig + 1) % NDIG;
               m_blank = 1'b1;
            end else begin
               m_left--;
            end
         end
         if (fire) pend.push_back(load_bus.load_data);
      end
      m_dp = dp_mask;
   end

   function automatic logic [7:0] exp_disp();
      logic [7:0] d;
      int         nd;
      if (!m_run || m_blank) return 8'hFF;
      d = {~m_dp[m_dig], segtab[m_shadow[4*m_dig +: 4]][6:0]};
`ifdef LZ_BLANK_EN
      nd = 1;
      for (int i = 0; i < NDIG; i++) if (m_shadow[4*i +: 4] != 4'h0) nd = i + 1;
      if (m_dig >= nd) d[6:0] = 7'h7F;
`else
      nd = 0;
`endif
      return d;
   endfunction

   function automatic logic [NDIG-1:0] exp_an();
      logic [NDIG-1:0] a = '1;
      if (m_run && !m_blank) a[m_dig] = 1'b0;
      return a;
   endfunction

   always @(negedge clki) begin
      if (chk_on) begin
         check("model disp", disp, exp_disp());
         check("model an", an, exp_an());
         check("model load_ready", load_bus.load_ready, pend.size() == 0);
         check("model frame_done", frame_done,
               m_run && !m_blank && en && m_left == 1 && m_dig == NDIG - 1);
      end
   end

   task automatic wait_fd(input string name);
      int b = 0;
      do begin
         @(negedge clki);
         b++;
      end while (!frame_done && b < 200);
      check({name, " frame_done seen"}, frame_done, 1);
   endtask

   task automatic load_one(input logic [4*NDIG-1:0] v);
      @(posedge clki); #1;
      load_bus.load_valid = 1'b1;
      load_bus.load_data  = v;
      @(posedge clki); #1;
      load_bus.load_valid = 1'b0;
   endtask

   // Walk one full frame after a wrap, pinning anode/segment literals per digit.
   task automatic frame_lits(input string name, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3);
      logic [7:0]      dl [4];
      logic [NDIG-1:0] al [4];
      dl = '{d0, d1, d2, d3};
      al = '{4'hE, 4'hD, 4'hB, 4'h7};
      for (int s = 0; s < 4; s++) begin
         @(negedge clki);
         check({name, " blank an"}, an, 4'hF);
         check({name, " blank disp"}, disp, 8'hFF);
         for (int k = 0; k < SCAN_DIV; k++) begin
            @(negedge clki);
            check({name, " an"}, an, al[s]);
            check({name, " disp"}, disp, dl[s]);
         end
      end
      check({name, " wrap pulse"}, frame_done, 1);
   endtask

   initial begin
      load_bus.load_valid = 1'b0;
      load_bus.load_data  = '0;
      // Reset held with en low.
      repeat (3) begin
         @(negedge clki);
         check("rst disp", disp, 8'hFF);
         check("rst an", an, 4'hF);
         check("rst load_ready", load_bus.load_ready, 1);
         check("rst frame_done", frame_done, 0);
      end
      @(posedge clki); #1;
      rst = 1'b0;
      en  = 1'b1;
      load_bus.load_valid = 1'b1;
      load_bus.load_data  = 16'h12AF;
      @(posedge clki); #1;
      load_bus.load_valid = 1'b0;

      wait_fd("first wrap");
      frame_lits("scan 12AF", 8'h8E, 8'h88, 8'hA4, 8'hF9);

      // Load on the wrap-tick cycle: held a full extra frame.
      repeat (20) @(posedge clki); #1;
      load_bus.load_valid = 1'b1;
      load_bus.load_data  = 16'h3333;
      @(posedge clki); #1;
      load_bus.load_valid = 1'b0;
      @(negedge clki);
      check("wrap load ready low", load_bus.load_ready, 0);
      @(negedge clki);
      check("wrap load old digit", disp, 8'h8E);
      wait_fd("wrap load");
      check("wrap load still pending", load_bus.load_ready, 0);
      repeat (2) @(negedge clki);
      check("wrap load committed", disp, 8'hB0);
      check("wrap load ready high", load_bus.load_ready, 1);

      // Load one cycle before the wrap: commits at that wrap.
      wait_fd("pre-wrap sync");
      repeat (19) @(posedge clki); #1;
      load_bus.load_valid = 1'b1;
      load_bus.load_data  = 16'h5555;
      @(posedge clki); #1;
      load_bus.load_valid = 1'b0;
      @(negedge clki);
      check("pre-wrap pulse", frame_done, 1);
      repeat (2) @(negedge clki);
      check("pre-wrap committed", disp, 8'h92);
      check("pre-wrap ready", load_bus.load_ready, 1);

      // Freeze mid-slot.
      @(posedge clki); #1;
      en = 1'b0;
      @(negedge clki);
      check("freeze an", an, 4'hE);
      check("freeze disp", disp, 8'h92);
      repeat (10) @(posedge clki); #1;
      en = 1'b1;

      // Reset with a pending value.
      load_bus.load_valid = 1'b1;
      load_bus.load_data  = 16'hBEEF;
      @(posedge clki); #1;
      load_bus.load_valid = 1'b0;
      rst = 1'b1;
      @(posedge clki); #1;
      rst = 1'b0;
      @(negedge clki);
      check("mid rst disp", disp, 8'hFF);
      check("mid rst an", an, 4'hF);
      check("mid rst ready", load_bus.load_ready, 1);
      @(negedge clki);
      check("post rst digit0", disp, 8'hC0);
      check("post rst an", an, 4'hE);

      // Leading zeros.
      load_one(16'h0070);
      wait_fd("lz load");
`ifdef LZ_BLANK_EN
      frame_lits("lz 0070", 8'hC0, 8'hF8, 8'hFF, 8'hFF);
`else
      frame_lits("lz 0070", 8'hC0, 8'hF8, 8'hC0, 8'hC0);
`endif

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clki); #1;
         en                  = ($urandom_range(0, 9) != 0);
         load_bus.load_valid = ($urandom_range(0, 3) == 0);
         load_bus.load_data  = 16'($urandom);
         if ($urandom_range(0, 15) == 0) dp_mask = 4'($urandom);
         rst = ($urandom_range(0, 299) == 0);
      end
      @(posedge clki); #1;
      rst = 1'b0;
      @(negedge clki);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
